// File: rtl/store_buffer_if.sv
// Pipeline-side and memory-side signals of the store buffer, grouped per direction.
// master = pipeline + data memory environment, slave = the store buffer itself.
interface store_buffer_if #(
   parameter int DEPTH = 4
) ();
   logic                     st_valid;
   logic [31:0]              st_addr;
   logic [31:0]              st_data;
   logic                     st_ready;

   logic                     ld_valid;
   logic [31:0]              ld_addr;
   logic [31:0]              ld_data;
   logic                     ld_hit;

   logic                     mem_write;
   logic                     mem_read;
   logic [31:0]              mem_addr;
   logic [31:0]              mem_din;
   logic [31:0]              mem_dout;

   logic                     empty;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_dout,
      input  st_ready, ld_data, ld_hit, mem_write, mem_read, mem_addr, mem_din,
             empty, count
   );

   modport slave (
      input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_dout,
      output st_ready, ld_data, ld_hit, mem_write, mem_read, mem_addr, mem_din,
             empty, count
   );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer with youngest-match load forwarding; loads are combinational (0 cycles).
// Load misses own the memory port; stores stall via st_ready while the buffer is full.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 10
) (
   input  logic          clk_i,
   input  logic          reset_ni,
   store_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [IDX_W-1:0] addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic [IDX_W-1:0] st_idx;
   logic [IDX_W-1:0] ld_idx;
   logic             full;
   logic             push;
   logic             drain;
   logic             ld_miss;
   logic             fwd_hit;
   logic [31:0]      fwd_data;
   logic [PTR_W-1:0] slot;
   logic             unused_addr_bits;

   assign st_idx = bus.st_addr[IDX_W-1:0];
   assign ld_idx = bus.ld_addr[IDX_W-1:0];
   assign unused_addr_bits = ^{bus.st_addr[31:IDX_W], bus.ld_addr[31:IDX_W]};

   // Full is taken from the registered count, so a drain this cycle does not free a slot early.
   assign full = (count_q == CNT_W'(DEPTH));
   assign push = reset_ni && bus.st_valid && !full;

   // Walk oldest to youngest so the last match written is the youngest one.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      slot     = rd_ptr_q;
      for (int k = 0; k < DEPTH; k++) begin
         slot = rd_ptr_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (addr_q[slot] == ld_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[slot];
         end
      end
   end

   assign bus.ld_hit  = reset_ni && bus.ld_valid && fwd_hit;
   assign ld_miss     = bus.ld_valid && !bus.ld_hit;
   assign drain       = reset_ni && !ld_miss && (count_q != '0);
   assign bus.ld_data = bus.ld_hit ? fwd_data : bus.mem_dout;

   always_comb begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_din   = '0;
      if (ld_miss) begin
         bus.mem_read  = 1'b1;
         bus.mem_addr  = {{(32-IDX_W){1'b0}}, ld_idx};
      end else if (drain) begin
         bus.mem_write = 1'b1;
         bus.mem_addr  = {{(32-IDX_W){1'b0}}, addr_q[rd_ptr_q]};
         bus.mem_din   = data_q[rd_ptr_q];
      end
   end

   // Status is forced to its reset view while reset is asserted, not only after the edge.
   assign bus.st_ready = !reset_ni || !full;
   assign bus.empty    = !reset_ni || (count_q == '0);
   assign bus.count    = reset_ni ? count_q : '0;

   always_comb begin
      wr_ptr_d = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = drain ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(drain);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[wr_ptr_q] <= st_idx;
         data_q[wr_ptr_q] <= bus.st_data;
      end
   end

   a_count_range: assert property (@(posedge clk_i) disable iff (!reset_ni)
      count_q <= CNT_W'(DEPTH));
   a_port_excl: assert property (@(posedge clk_i) disable iff (!reset_ni)
      !(bus.mem_read && bus.mem_write));
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int IDX_W = 10;

   typedef struct {
      logic [IDX_W-1:0] a;
      logic [31:0]      d;
   } entry_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   entry_t      q[$];
   logic [31:0] model_mem [1024];
   logic [31:0] mem [1024];

   logic        last_hit;
   logic [31:0] last_ldd;
   logic        last_mrd;
   logic        last_mwr;

   store_buffer_if #(.DEPTH(DEPTH)) bus ();

   store_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk_i    (clk),
      .reset_ni (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_dout = mem[bus.mem_addr[IDX_W-1:0]];

   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr[IDX_W-1:0]] <= bus.mem_din;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: drive at negedge, check against the model, then retire the model at posedge.
   task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic rn);
      logic        full;
      logic        e_hit;
      logic [31:0] e_fd;
      logic        e_miss;
      logic        e_drain;
      entry_t      e;
      @(negedge clk);
      rst_n        = rn;
      bus.st_valid = sv;
      bus.st_addr  = sa;
      bus.st_data  = sd;
      bus.ld_valid = lv;
      bus.ld_addr  = la;
      #1;
      full  = (q.size() == DEPTH);
      e_hit = 1'b0;
      e_fd  = '0;
      if (rn && lv) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == la[IDX_W-1:0]) begin
               e_hit = 1'b1;
               e_fd  = q[i].d;
               break;
            end
         end
      end
      e_miss  = lv && !e_hit;
      e_drain = rn && !e_miss && (q.size() > 0);

      check("st_ready", bus.st_ready, !rn || !full);
      check("empty", bus.empty, !rn || (q.size() == 0));
      check("count", 32'(bus.count), rn ? q.size() : 0);
      check("ld_hit", bus.ld_hit, e_hit);
      check("mem_read", bus.mem_read, e_miss);
      check("mem_write", bus.mem_write, e_drain);
      if (lv) check("ld_data", bus.ld_data, e_hit ? e_fd : model_mem[la[IDX_W-1:0]]);
      if (e_miss)
         check("mem_addr_rd", bus.mem_addr, {22'd0, la[IDX_W-1:0]});
      else if (e_drain) begin
         check("mem_addr_wr", bus.mem_addr, {22'd0, q[0].a});
         check("mem_din", bus.mem_din, q[0].d);
      end else
         check("mem_addr_idle", bus.mem_addr, 32'd0);

      last_hit = bus.ld_hit;
      last_ldd = bus.ld_data;
      last_mrd = bus.mem_read;
      last_mwr = bus.mem_write;

      @(posedge clk);
      if (!rn) begin
         q.delete();
      end else begin
         if (e_drain) begin
            model_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
         end
         if (sv && !full) begin
            e.a = sa[IDX_W-1:0];
            e.d = sd;
            q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] la;
      logic        sv;
      logic        lv;
      logic        rn;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.st_valid = 1'b0;
      bus.st_addr  = '0;
      bus.st_data  = '0;
      bus.ld_valid = 1'b0;
      bus.ld_addr  = '0;
      for (int i = 0; i < 1024; i++) begin
         mem[i]       = 32'h5A00_0000 + 32'(i);
         model_mem[i] = 32'h5A00_0000 + 32'(i);
      end

      // Reset with a store presented: nothing may be captured.
      step(1'b1, 32'h50, 32'h55, 1'b0, 32'd0, 1'b0);
      step(1'b1, 32'h50, 32'h55, 1'b0, 32'd0, 1'b0);
      idle(1);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_empty", bus.empty, 1'b1);

      // Fill/drain in order.
      step(1'b1, 32'h10, 32'h11, 1'b0, 32'd0, 1'b1);
      step(1'b1, 32'h20, 32'h22, 1'b0, 32'd0, 1'b1);
      step(1'b1, 32'h30, 32'h33, 1'b0, 32'd0, 1'b1);
      step(1'b1, 32'h40, 32'h44, 1'b0, 32'd0, 1'b1);
      idle(4);
      #1;
      check("mem10", mem[10'h10], 32'h11);
      check("mem20", mem[10'h20], 32'h22);
      check("mem30", mem[10'h30], 32'h33);
      check("mem40", mem[10'h40], 32'h44);
      check("fd_empty", bus.empty, 1'b1);

      // Full while misses block the port.
      for (int i = 0; i < 5; i++)
         step(1'b1, 32'h50 + 32'(i), 32'hC0 + 32'(i), 1'b1, 32'h3FF, 1'b1);
      #1;
      check("full_count", 32'(bus.count), 32'd4);
      check("full_ready", bus.st_ready, 1'b0);
      idle(4);

      // Youngest matching entry is forwarded.
      step(1'b1, 32'h08, 32'hAAAA, 1'b1, 32'h3FF, 1'b1);
      step(1'b1, 32'h08, 32'hBBBB, 1'b1, 32'h3FF, 1'b1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h08, 1'b1);
      check("fwd_hit", last_hit, 1'b1);
      check("fwd_data", last_ldd, 32'hBBBB);
      check("fwd_noread", last_mrd, 1'b0);
      idle(2);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h08, 1'b1);
      check("mem_hit", last_hit, 1'b0);
      check("mem_data", last_ldd, 32'hBBBB);

      // Misses keep priority over queued stores.
      step(1'b1, 32'h21, 32'h2121, 1'b1, 32'h3FF, 1'b1);
      step(1'b1, 32'h22, 32'h2222, 1'b1, 32'h3FF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'd0, 32'd0, 1'b1, 32'h100, 1'b1);
         check("miss_read", last_mrd, 1'b1);
         #1;
         check("miss_count", 32'(bus.count), 32'd2);
      end
      step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      check("resume_wr", last_mwr, 1'b1);

      // Push alongside drain; a same-cycle load does not see the new store.
      step(1'b1, 32'h23, 32'h2323, 1'b1, 32'h3FF, 1'b1);
      step(1'b1, 32'h60, 32'h6060, 1'b0, 32'd0, 1'b1);
      #1;
      check("pd_count", 32'(bus.count), 32'd2);
      step(1'b1, 32'h61, 32'h6161, 1'b1, 32'h61, 1'b1);
      check("pd_nohit", last_hit, 1'b0);
      idle(5);

      // Random traffic over a small address window to provoke hits and repeats.
      for (int i = 0; i < 600; i++) begin
         sv = 1'($urandom_range(0, 1));
         ra = $urandom_range(0, 7);
         lv = ($urandom_range(0, 2) == 0);
         la = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 7));
         la = la | ({$urandom} & 32'hFFFF_FC00);
         ra = ra | ({$urandom} & 32'hFFFF_FC00);
         rn = ($urandom_range(0, 79) != 0);
         if (!rn) lv = 1'b0;
         step(sv, ra, $urandom, lv, la, rn);
      end
      idle(DEPTH + 2);
      #1;
      for (int i = 0; i < 1024; i++) check("final_mem", mem[i], model_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
